// File: rtl/addr_multiply_if.sv
// Operand/result bundle for the address-unit multiplier.
// The o_ovf signal exists only when ADDR_MUL_OVF_EN is defined.
interface addr_multiply_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i_Aj;
    logic [WIDTH-1:0] i_Ak;
    logic [WIDTH-1:0] o_Ai;
`ifdef ADDR_MUL_OVF_EN
    logic             o_ovf;

    modport master (output i_Aj, output i_Ak, input  o_Ai, input  o_ovf);
    modport slave  (input  i_Aj, input  i_Ak, output o_Ai, output o_ovf);
`else
    modport master (output i_Aj, output i_Ak, input  o_Ai);
    modport slave  (input  i_Aj, input  i_Ak, output o_Ai);
`endif
endinterface

// File: rtl/addr_multiply.sv
// Pipelined address multiplier: Ai = (Aj * Ak) mod 2^WIDTH, fixed LEVEL-clock latency, one pair per clock.
// Optional ADDR_MUL_OVF_EN carries the high product word and adds a pipeline-aligned o_ovf flag.
module addr_multiply #(
    parameter int WIDTH = 32,
    parameter int LEVEL = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    addr_multiply_if.slave bus
);
    localparam int MID = LEVEL - 2;
    localparam int NSL = (MID == 0) ? 1 : MID;
    localparam int SL  = (WIDTH + NSL - 1) / NSL;
`ifdef ADDR_MUL_OVF_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH;
`endif

    typedef logic [ACC_W-1:0] acc_t;

    // Sum of (Aj << (lo+b)) for each set bit b of the low SL bits of ak.
    function automatic acc_t slice_pp(input logic [WIDTH-1:0] aj,
                                      input logic [WIDTH-1:0] ak,
                                      input int               lo);
        acc_t acc;
        acc_t ajx;
        acc = '0;
        ajx = acc_t'(aj);
        for (int b = 0; b < SL; b++) begin
            if (ak[b]) acc = acc + (ajx << (lo + b));
        end
        return acc;
    endfunction

    logic [WIDTH-1:0] aj_q  [0:NSL-1];
    logic [WIDTH-1:0] ak_q  [0:NSL-1];
    acc_t             sum_q [0:MID];
    acc_t             res_next;
    logic [WIDTH-1:0] ai_q;

    generate
        if (MID == 0) begin : g_direct
            assign res_next = slice_pp(aj_q[0], ak_q[0], 0);
        end else begin : g_staged
            assign res_next = sum_q[MID];
        end
    endgenerate

    // ak is shifted down each stage so every middle stage consumes its own low SL bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSL; s++) begin
                aj_q[s] <= '0;
                ak_q[s] <= '0;
            end
            for (int s = 0; s <= MID; s++) begin
                sum_q[s] <= '0;
            end
            ai_q <= '0;
        end else begin
            aj_q[0]  <= bus.i_Aj;
            ak_q[0]  <= bus.i_Ak;
            sum_q[0] <= '0;
            for (int s = 1; s < NSL; s++) begin
                aj_q[s] <= aj_q[s-1];
                ak_q[s] <= ak_q[s-1] >> SL;
            end
            for (int s = 1; s <= MID; s++) begin
                sum_q[s] <= sum_q[s-1] + slice_pp(aj_q[s-1], ak_q[s-1], (s - 1) * SL);
            end
            ai_q <= res_next[WIDTH-1:0];
        end
    end

    assign bus.o_Ai = ai_q;

`ifdef ADDR_MUL_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= |res_next[ACC_W-1:WIDTH];
    end

    assign bus.o_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_addr_multiply.sv
// Self-checking bench for addr_multiply: constant vector table, sweep and random streams against a delay-queue model.
module tb_addr_multiply;
    localparam int WIDTH = 32;
    localparam int LEVEL = 6;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    addr_multiply_if #(.WIDTH(WIDTH)) bus ();

    addr_multiply #(.WIDTH(WIDTH), .LEVEL(LEVEL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: full 64-bit products, delayed LEVEL edges; front = what o_Ai shows now.
    logic [63:0] mq[$];

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < LEVEL; i++) mq.push_back(64'd0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            mq.push_back(64'(bus.i_Aj) * 64'(bus.i_Ak));
            void'(mq.pop_front());
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("model_ai", 64'(bus.o_Ai), {32'd0, mq[0][31:0]});
`ifdef ADDR_MUL_OVF_EN
        check("model_ovf", 64'(bus.o_ovf), 64'(|mq[0][63:32]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic [31:0] aj;
        logic [31:0] ak;
        logic [31:0] exp_ai;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
        tbl[1] = '{32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 1'b1};
        tbl[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        tbl[3] = '{32'h1234_5678, 32'h0000_0001, 32'h1234_5678, 1'b0};
        tbl[4] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[5] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0};
        tbl[6] = '{32'h0000_0000, 32'hABCD_EF01, 32'h0000_0000, 1'b0};
        tbl[7] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0};

        model_clear();
        rst_n    = 1'b0;
        bus.i_Aj = 32'd5;
        bus.i_Ak = 32'd7;

        // Reset hold: output pinned at zero.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("reset_hold", 64'(bus.o_Ai), 64'd0);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= LEVEL; e++) begin
            tick();
            if (e < LEVEL) check("post_reset_zero", 64'(bus.o_Ai), 64'd0);
            else           check("post_reset_35", 64'(bus.o_Ai), 64'd35);
        end

        // Boundary table: single vector, then bubbles of zeros until it emerges.
        for (int v = 0; v < 8; v++) begin
            bus.i_Aj = tbl[v].aj;
            bus.i_Ak = tbl[v].ak;
            tick();
            bus.i_Aj = 32'd0;
            bus.i_Ak = 32'd0;
            for (int c = 1; c < LEVEL; c++) tick();
            check($sformatf("table_ai[%0d]", v), 64'(bus.o_Ai), 64'(tbl[v].exp_ai));
`ifdef ADDR_MUL_OVF_EN
            check($sformatf("table_ovf[%0d]", v), 64'(bus.o_ovf), 64'(tbl[v].exp_ovf));
`endif
        end

        // Back-to-back sweep.
        for (int i = 0; i <= 62; i++) begin
            for (int j = 0; j <= 62; j++) begin
                bus.i_Aj = 32'(i);
                bus.i_Ak = 32'(j);
                tick();
            end
        end
        for (int c = 1; c < LEVEL; c++) tick();
        check("sweep_62x62", 64'(bus.o_Ai), 64'd3844);

        // Random stream.
        for (int c = 0; c < 500; c++) begin
            bus.i_Aj = $urandom;
            bus.i_Ak = (c % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            tick();
        end

        // Mid-flight reset: three pairs in the pipe, reset asserted between edges.
        bus.i_Aj = 32'd3; bus.i_Ak = 32'd4; tick();
        bus.i_Aj = 32'd5; bus.i_Ak = 32'd6; tick();
        bus.i_Aj = 32'd7; bus.i_Ak = 32'd8; tick();
        bus.i_Aj = 32'd0; bus.i_Ak = 32'd0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", 64'(bus.o_Ai), 64'd0);
`ifdef ADDR_MUL_OVF_EN
        check("async_reset_ovf", 64'(bus.o_ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * LEVEL; c++) begin
            tick();
            check("no_stale_product", 64'(bus.o_Ai), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
